// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: register file with two combinational read ports, per-register
// busy (reservation) bits, a registered one-hot write-enable copy (ld_vec) and a
// sticky out-of-range select flag (sel_err).
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read port that
// selects the register being written this cycle sees wr_data and busy=0.

// One register plus its busy bit.
module reg_file_cell #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              rsv_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  // Next state: a reservation beats the clearing effect of a same-cycle write.
  always_comb begin
    data_d = we_i ? d_i : data_q;
    busy_d = busy_q;
    if (we_i)  busy_d = 1'b0;
    if (rsv_i) busy_d = 1'b1;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign q_o    = data_q;
  assign busy_o = busy_q;
endmodule

module reg_file_ctrl #(
  parameter  int NUM_REGS = 8,
  parameter  int DATA_W   = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_signal,
  input  logic [ADDR_W-1:0]   drmux_signal,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_sel,
  input  logic [ADDR_W-1:0]   sr1_sel,
  input  logic [ADDR_W-1:0]   sr2_sel,
  output logic [DATA_W-1:0]   sr1_out,
  output logic [DATA_W-1:0]   sr2_out,
  output logic                sr1_busy,
  output logic                sr2_busy,
  output logic [NUM_REGS-1:0] ld_vec,
  output logic                sel_err
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_REGS-1:0]             dec_en, rsv_en;
  logic [NUM_REGS-1:0]             ld_vec_q;
  logic                            sel_err_q, sel_err_d;
  logic                            wr_ok, rsv_ok, sr1_ok, sr2_ok;

  function automatic logic in_rng(input logic [ADDR_W-1:0] s);
    return 32'(s) < 32'(NUM_REGS);
  endfunction

  assign wr_ok  = in_rng(drmux_signal);
  assign rsv_ok = in_rng(rsv_sel);
  assign sr1_ok = in_rng(sr1_sel);
  assign sr2_ok = in_rng(sr2_sel);

  // One-hot decode of write and reserve selects; out-of-range selects match no lane.
  always_comb begin
    dec_en = '0;
    rsv_en = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      dec_en[k] = ld_signal && (drmux_signal == ADDR_W'(k));
      rsv_en[k] = rsv_valid && (rsv_sel == ADDR_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg_file_cell #(.DATA_W(DATA_W)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (dec_en[g]),
      .rsv_i  (rsv_en[g]),
      .d_i    (wr_data),
      .q_o    (regs[g]),
      .busy_o (busy[g])
    );
  end

  // Read ports: mux over stored state; out-of-range selects read 0 / not busy.
  always_comb begin
    sr1_out  = '0;
    sr2_out  = '0;
    sr1_busy = 1'b0;
    sr2_busy = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (sr1_sel == ADDR_W'(k)) begin
        sr1_out  = regs[k];
        sr1_busy = busy[k];
      end
      if (sr2_sel == ADDR_W'(k)) begin
        sr2_out  = regs[k];
        sr2_busy = busy[k];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (ld_signal && wr_ok && sr1_ok && (sr1_sel == drmux_signal)) begin
      sr1_out  = wr_data;
      sr1_busy = 1'b0;
    end
    if (ld_signal && wr_ok && sr2_ok && (sr2_sel == drmux_signal)) begin
      sr2_out  = wr_data;
      sr2_busy = 1'b0;
    end
`endif
  end

  // Sticky error: any qualified out-of-range select, read selects always qualified.
  always_comb begin
    sel_err_d = sel_err_q
              | (ld_signal & ~wr_ok)
              | (rsv_valid & ~rsv_ok)
              | ~sr1_ok | ~sr2_ok;
  end

  // Registered copy of this cycle's write enables and the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_vec_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      ld_vec_q  <= dec_en;
      sel_err_q <= sel_err_d;
    end
  end

  assign ld_vec  = ld_vec_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl (NUM_REGS=6 to exercise out-of-range selects):
// directed vector table, bypass and async-reset sequences, then random
// traffic compared against a behavioural model.
module tb_reg_file_ctrl;
  localparam int N  = 6;
  localparam int AW = 3;
  localparam int DW = 16;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst_n;
  logic          ld_signal, rsv_valid;
  logic [AW-1:0] drmux_signal, rsv_sel, sr1_sel, sr2_sel;
  logic [DW-1:0] wr_data, sr1_out, sr2_out;
  logic          sr1_busy, sr2_busy, sel_err;
  logic [N-1:0]  ld_vec;

  reg_file_ctrl #(.NUM_REGS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_signal(ld_signal), .drmux_signal(drmux_signal),
    .wr_data(wr_data), .rsv_valid(rsv_valid), .rsv_sel(rsv_sel),
    .sr1_sel(sr1_sel), .sr2_sel(sr2_sel), .sr1_out(sr1_out), .sr2_out(sr2_out),
    .sr1_busy(sr1_busy), .sr2_busy(sr2_busy), .ld_vec(ld_vec), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [DW-1:0] m_regs [N];
  bit            m_busy [N];
  logic [N-1:0]  m_ldvec;
  bit            m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_regs[k] = '0;
      m_busy[k] = 1'b0;
    end
    m_ldvec = '0;
    m_err   = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_rd(input int sel);
    if (sel >= N) return '0;
    if (BYP && ld_signal && int'(drmux_signal) < N && int'(drmux_signal) == sel) return wr_data;
    return m_regs[sel];
  endfunction

  function automatic logic exp_bz(input int sel);
    if (sel >= N) return 1'b0;
    if (BYP && ld_signal && int'(drmux_signal) < N && int'(drmux_signal) == sel) return 1'b0;
    return m_busy[sel];
  endfunction

  // Drive one cycle of inputs at negedge, check outputs, then advance the model
  // to what the coming rising edge should produce.
  task automatic apply(input logic ld, input int dr, input logic [DW-1:0] wd,
                       input logic rsv, input int rs, input int s1, input int s2);
    @(negedge clk);
    ld_signal = ld; drmux_signal = AW'(dr); wr_data = wd;
    rsv_valid = rsv; rsv_sel = AW'(rs); sr1_sel = AW'(s1); sr2_sel = AW'(s2);
    #1;
    chk("sr1_out",  32'(sr1_out),  32'(exp_rd(s1)));
    chk("sr2_out",  32'(sr2_out),  32'(exp_rd(s2)));
    chk("sr1_busy", 32'(sr1_busy), 32'(exp_bz(s1)));
    chk("sr2_busy", 32'(sr2_busy), 32'(exp_bz(s2)));
    chk("ld_vec",   32'(ld_vec),   32'(m_ldvec));
    chk("sel_err",  32'(sel_err),  32'(m_err));
    m_ldvec = '0;
    if (ld && dr < N) begin
      m_regs[dr] = wd;
      m_busy[dr] = 1'b0;
      m_ldvec[dr] = 1'b1;
    end
    if (rsv && rs < N) m_busy[rs] = 1'b1;
    if ((ld && dr >= N) || (rsv && rs >= N) || s1 >= N || s2 >= N) m_err = 1'b1;
  endtask

  typedef struct {
    logic ld; int dr; logic [DW-1:0] wd; logic rsv; int rs; int s1; int s2;
    logic [DW-1:0] e_s1; logic e_b2; logic [N-1:0] e_ldv; logic e_err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Expected values are those visible before the edge of the row's own cycle.
    tbl[0]  = '{1'b0, 0, 16'h0000, 1'b0, 0, 0, 1, 16'h0000, 1'b0, 6'b000000, 1'b0};
    tbl[1]  = '{1'b1, 3, 16'hBEEF, 1'b0, 0, 0, 0, 16'h0000, 1'b0, 6'b000000, 1'b0};
    tbl[2]  = '{1'b0, 0, 16'h0000, 1'b0, 0, 3, 0, 16'hBEEF, 1'b0, 6'b001000, 1'b0};
    tbl[3]  = '{1'b0, 0, 16'h0000, 1'b1, 5, 3, 5, 16'hBEEF, 1'b0, 6'b000000, 1'b0};
    tbl[4]  = '{1'b0, 0, 16'h0000, 1'b0, 0, 3, 5, 16'hBEEF, 1'b1, 6'b000000, 1'b0};
    tbl[5]  = '{1'b1, 5, 16'h5555, 1'b0, 0, 3, 4, 16'hBEEF, 1'b0, 6'b000000, 1'b0};
    tbl[6]  = '{1'b0, 0, 16'h0000, 1'b0, 0, 5, 5, 16'h5555, 1'b0, 6'b100000, 1'b0};
    tbl[7]  = '{1'b1, 5, 16'h6666, 1'b1, 5, 3, 4, 16'hBEEF, 1'b0, 6'b000000, 1'b0};
    tbl[8]  = '{1'b0, 0, 16'h0000, 1'b0, 0, 5, 5, 16'h6666, 1'b1, 6'b100000, 1'b0};
    tbl[9]  = '{1'b1, 6, 16'hFFFF, 1'b0, 0, 0, 1, 16'h0000, 1'b0, 6'b000000, 1'b0};
    tbl[10] = '{1'b0, 0, 16'h0000, 1'b0, 0, 5, 5, 16'h6666, 1'b1, 6'b000000, 1'b1};
    tbl[11] = '{1'b0, 0, 16'h0000, 1'b1, 7, 6, 5, 16'h0000, 1'b1, 6'b000000, 1'b1};

    // Reset with out-of-range selects applied: reset must dominate.
    rst_n = 1'b0; ld_signal = 1'b0; drmux_signal = '0; wr_data = '0;
    rsv_valid = 1'b0; rsv_sel = '0; sr1_sel = 3'd7; sr2_sel = 3'd6;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel_err", 32'(sel_err), 32'h0);
    chk("rst_ld_vec",  32'(ld_vec),  32'h0);
    sr1_sel = 3'd0; sr2_sel = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 6; r++) apply(1'b0, 0, '0, 1'b0, 0, r, 5 - r);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ld, tbl[i].dr, tbl[i].wd, tbl[i].rsv, tbl[i].rs, tbl[i].s1, tbl[i].s2);
      chk($sformatf("tbl%0d_sr1", i),  32'(sr1_out),  32'(tbl[i].e_s1));
      chk($sformatf("tbl%0d_b2", i),   32'(sr2_busy), 32'(tbl[i].e_b2));
      chk($sformatf("tbl%0d_ldv", i),  32'(ld_vec),   32'(tbl[i].e_ldv));
      chk($sformatf("tbl%0d_err", i),  32'(sel_err),  32'(tbl[i].e_err));
    end

    // Same-cycle write and read of R5 (R5 holds 0x6666 and is busy)
    apply(1'b1, 5, 16'h1234, 1'b0, 0, 5, 5);
    chk("byp_sr1", 32'(sr1_out), BYP ? 32'h1234 : 32'h6666);
    chk("byp_b2",  32'(sr2_busy), BYP ? 32'h0 : 32'h1);
    apply(1'b0, 0, '0, 1'b0, 0, 5, 0);
    chk("post_wr_sr1", 32'(sr1_out), 32'h1234);

    // Async reset between edges after a write+reserve to R2
    apply(1'b1, 2, 16'hA5A5, 1'b1, 2, 0, 1);
    apply(1'b1, 2, 16'hFFFF, 1'b1, 4, 2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sr1",  32'(sr1_out),  32'h0);
    chk("async_b2",   32'(sr2_busy), 32'h0);
    chk("async_ldv",  32'(ld_vec),   32'h0);
    chk("async_err",  32'(sel_err),  32'h0);
    @(negedge clk);
    rst_n = 1'b1; ld_signal = 1'b0; rsv_valid = 1'b0;
    model_reset();
    apply(1'b0, 0, '0, 1'b0, 0, 2, 4);
    chk("rst_discard_r2", 32'(sr1_out), 32'h0);
    chk("rst_discard_b4", 32'(sr2_busy), 32'h0);

    // Random traffic: in-range first, then with out-of-range selects mixed in.
    for (int i = 0; i < 400; i++) begin
      int hi;
      hi = (i < 250) ? N - 1 : 7;
      apply(1'($urandom_range(0, 1)), int'($urandom_range(0, hi)), 16'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, hi)),
            int'($urandom_range(0, hi)), int'($urandom_range(0, hi)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
